// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 operation codes, the M-extension funct7
// value and the sequencer state encoding.
package rv32m_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Multiply/divide datapath: operand magnitudes and signs, a 64-bit
// accumulator advanced one bit per step, and the final sign correction.
module muldiv_iter
  import rv32m_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] result_o
);

  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] bmag_q, bmag_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        signed_a, signed_b, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  always_comb begin
    signed_a  = (op_i == F3_MULH) || (op_i == F3_MULHSU) ||
                (op_i == F3_DIV)  || (op_i == F3_REM);
    signed_b  = (op_i == F3_MULH) || (op_i == F3_DIV) || (op_i == F3_REM);
    sign_a    = signed_a & a_i[31];
    sign_b    = signed_b & b_i[31];
    mag_a     = sign_a ? (32'd0 - a_i) : a_i;
    mag_b     = sign_b ? (32'd0 - b_i) : b_i;
    div_zero  = is_div_op(op_i) && (b_i == 32'd0);
    div_ovf   = ((op_i == F3_DIV) || (op_i == F3_REM)) &&
                (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    special_o = div_zero || div_ovf;
  end

  // Multiply shifts the product right past the multiplier; divide shifts the
  // dividend left into the partial remainder and restores on borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_trial = {1'b0, acc_q[63:31]} - {2'b00, bmag_q};
    div_next  = div_trial[33] ? {acc_q[62:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
  end

  always_comb begin
    op_d   = op_q;
    acc_d  = acc_q;
    bmag_d = bmag_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (load_i) begin
      op_d   = op_i;
      bmag_d = mag_b;
      if (special_o) begin
        // Preload quotient/remainder halves so the normal correction yields the result.
        negq_d = 1'b0;
        negr_d = 1'b0;
        acc_d  = div_zero ? {a_i, 32'hFFFF_FFFF} : {32'd0, 32'h8000_0000};
      end else begin
        negq_d = sign_a ^ sign_b;
        negr_d = sign_a;
        acc_d  = {32'd0, mag_a};
      end
    end else if (step_i) begin
      acc_d = is_div_op(op_q) ? div_next : mul_next;
    end
  end

  // Correction works on the next-state value so the last step's result can be
  // registered on the same edge that enters DONE.
  always_comb begin
    prod = negq_d ? (64'd0 - acc_d) : acc_d;
    quot = negq_d ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    rem  = negr_d ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
    case (op_d)
      F3_MUL:                       result_o = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod[63:32];
      F3_DIV, F3_DIVU:              result_o = quot;
      default:                      result_o = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 3'd0;
      acc_q  <= 64'd0;
      bmag_q <= 32'd0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      acc_q  <= acc_d;
      bmag_q <= bmag_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage RV32M sequencer: accepts one M operation, stalls the pipeline for
// the 32 iterations, then presents a registered result for one cycle.
module ex_muldiv_ctrl
  import rv32m_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  muldiv_state_e state_q, state_d;
  logic [4:0]    count_q, count_d;
  logic [31:0]   result_q;
  logic          load, step, special;
  logic [31:0]   dp_result;

  muldiv_iter u_iter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .op_i      (funct3),
    .a_i       (rs1_data),
    .b_i       (rs2_data),
    .special_o (special),
    .result_o  (dp_result)
  );

  // start is deliberately ignored in DONE: the stalled instruction still holds it.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    load         = 1'b0;
    step         = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          stall   = 1'b1;
          count_d = 5'd0;
          state_d = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        stall   = 1'b1;
        step    = !flush;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          count_d = 5'd0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = !flush;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      count_d = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        result_q <= dp_result;
      end
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: a table of hand-computed M operations
// plus sequences for flush, reset and back-to-back starts.
module tb_ex_muldiv_ctrl;
  import rv32m_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int testsRun;
  int testsFailed;
  int validCount;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    int          expLatency;
  } vec_t;

  vec_t vecs[16];

  ex_muldiv_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts result_valid pulses using the values settled before each edge.
  always @(posedge clk) begin
    if (result_valid === 1'b1) validCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    #1;
  endtask

  // Counts stall-high cycles from the current one, then checks the DONE cycle.
  task automatic waitDone(input string name, input int expLatency,
                          input logic [31:0] expResult);
    int cycles;
    cycles = 0;
    while (stall === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput({name, " latency"}, cycles, expLatency);
    checkOutput({name, " valid"}, {31'd0, result_valid}, 32'd1);
    checkOutput({name, " result"}, result, expResult);
  endtask

  initial begin
    int base;
    testsRun    = 0;
    testsFailed = 0;
    validCount  = 0;

    vecs[0]  = '{"mul 7*-3",        F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulhu -1*-1",     F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{"mulh -1*-1",      F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{"mulhsu -1*-1",    F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div -7/2",        F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem -7/2",        F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu 100/7",      F3_DIVU,   32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{"remu 100/7",      F3_REMU,   32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{"div 7/-2",        F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[9]  = '{"rem 7/-2",        F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33};
    vecs[10] = '{"divu 5/0",        F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{"remu 5/0",        F3_REMU,   32'd5,          32'd0,         32'd5,         1};
    vecs[12] = '{"div ovf",         F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[13] = '{"rem ovf",         F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[14] = '{"mulhu 0x12345678*16", F3_MULHU, 32'h1234_5678, 32'h10,      32'd1,         33};
    vecs[15] = '{"mul 0x12345678*16",   F3_MUL,   32'h1234_5678, 32'h10,      32'h2345_6780, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset valid", {31'd0, result_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b);
      waitDone(vecs[i].name, vecs[i].expLatency, vecs[i].expResult);
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput({vecs[i].name, " idle busy"}, {31'd0, busy}, 32'd0);
      checkOutput({vecs[i].name, " idle valid"}, {31'd0, result_valid}, 32'd0);
      checkOutput({vecs[i].name, " held result"}, result, vecs[i].expResult);
    end

    // flush in the same cycle as start: not accepted
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; rs1_data = 32'd1000; rs2_data = 32'd3; flush = 1'b1;
    #1;
    checkOutput("flush+start stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush+start busy", {31'd0, busy}, 32'd0);

    // flush during the 10th stall cycle of a DIV
    base = validCount;
    applyStimulus(F3_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("pre-flush busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    checkOutput("post-flush busy", {31'd0, busy}, 32'd0);
    checkOutput("post-flush stall", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("flushed valid pulses", validCount - base, 32'd0);

    // same scenario with rst: everything returns to reset values
    applyStimulus(F3_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid-op reset stall", {31'd0, stall}, 32'd0);
    checkOutput("mid-op reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid-op reset valid", {31'd0, result_valid}, 32'd0);
    checkOutput("mid-op reset result", result, 32'd0);

    // start held through DONE, then a second op one cycle after DONE
    base = validCount;
    applyStimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    waitDone("held mul", 33, 32'hFFFF_FFEB);
    @(negedge clk);
    funct3 = F3_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
    #1;
    checkOutput("no restart busy", {31'd0, busy}, 32'd0);
    checkOutput("second start stall", {31'd0, stall}, 32'd1);
    waitDone("b2b divu", 33, 32'd14);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("b2b valid pulses", validCount - base, 32'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the EX stage. It accepts one M-extension operation from the EX operands, runs a 32-step shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. It then presents the result for one cycle so the EX/MEM register can capture it instead of the ALU result.

## Interface
Parameters: none; width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid M-extension instruction (opcode OP, funct7 = 0000001)
- funct3  in  3  M operation selector
- rs1_data  in  32  operand A, the forwarded EX value
- rs2_data  in  32  operand B, the forwarded EX value
- flush  in  1  kill the in-flight operation (branch or exception flush)
- stall  out  1  hold PC, IF/ID and ID/EX this cycle
- busy  out  1  state is not IDLE
- result_valid  out  1  result is valid this cycle
- result  out  32  M-operation result

## Operation
- funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- States:
  - IDLE: on start && !flush, latch funct3 and both operands. Go to DONE if the operation is a special case, else to CALC with count = 0.
  - CALC: one iteration per cycle, count increments. When count == 31, go to DONE.
  - DONE: result_valid = 1. Unconditionally return to IDLE next cycle.
- start is ignored in DONE. The stalled instruction is still asserting start in that cycle and must not restart.
- Multiply:
  - Operate on magnitudes; take the signs from rs1 for MULH/MULHSU and from rs2 for MULH only.
  - Build a 64-bit product by shift-add, one multiplier bit per cycle.
  - Negate the product if sign_a XOR sign_b.
  - MUL returns product[31:0]; the other three return product[63:32].
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle; DIV/REM are signed.
  - Quotient is negated if sign_a XOR sign_b; remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no CALC:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- flush has priority over start and over every state: the next state is IDLE, result_valid stays 0, and no result is produced.
- rst forces IDLE and clears all internal registers.

## Timing
- Reset values:
  - outputs: stall = 0, busy = 0, result_valid = 0, result = 0
  - internal: state = IDLE, count = 0
- stall is combinational and equals (state == IDLE && start && !flush) || state == CALC. It is low in DONE, so the pipeline advances on the DONE edge and captures result.
- Normal latency:
  - start is sampled at edge E0; CALC spans E1–E32; result_valid is high in the cycle after E32.
  - stall is therefore high for 33 consecutive cycles.
- Special-case latency: result_valid is high in the cycle after E0, and stall is high for 1 cycle.
- result is registered. It holds its last value outside DONE; consumers must qualify it with result_valid.
- Back-to-back operations: a new start is accepted in the IDLE cycle immediately after DONE. The minimum spacing between two starts is 34 cycles.
- A flush in the same cycle as start means the operation is not accepted and stall = 0.

## Structure
- Shared package `rv32m_pkg`:
  - funct3 constants (MUL … REMU)
  - state encoding typedef (IDLE, CALC, DONE)
  - the M-extension funct7 constant 7'b0000001
- Sub-module `muldiv_iter`: the datapath, comprising the 64-bit accumulator/remainder register, operand magnitude and sign logic, one-iteration step and final correction. It is driven by load, step and op from the FSM in `ex_muldiv_ctrl`.
- The FSM, counter, stall and flush logic stay in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD: stall high 33 cycles, then result_valid for 1 cycle with result = 0xFFFFFFEB.
- High products of 0xFFFFFFFF × 0xFFFFFFFF: MULHU = 0xFFFFFFFE, MULH = 0x00000000, MULHSU = 0xFFFFFFFF; each has latency 33.
- Division:
  - DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD.
  - REM of the same operands gives 0xFFFFFFFF.
  - DIVU 100 / 7 gives 14; REMU of the same gives 2.
- Special cases, each with 1-cycle stall and result_valid on the next cycle:
  - DIVU 5 / 0 gives 0xFFFFFFFF; REMU 5 / 0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- flush asserted at cycle 10 of a DIV: state is IDLE next cycle, stall drops, and result_valid never asserts. A repeat using rst instead gives all outputs at their reset values.
- start held high through DONE: no restart and exactly one result_valid pulse. A second start 1 cycle after DONE is accepted and completes normally.
